// File: rtl/dsp_sys_arr_pkg.sv
// ---------------------------------------------------------------------------
// dsp_sys_arr_pkg : shared types and constants for the systolic-array system
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dsp_sys_arr_pkg;

    localparam int SNGL_FLT_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } loader_state_t;

    // Plain-vector encodings of loader_state_t for state registers
    localparam logic [1:0] LD_IDLE   = 2'd0;
    localparam logic [1:0] LD_STREAM = 2'd1;
    localparam logic [1:0] LD_DRAIN  = 2'd2;

    function automatic int loader_nbeats(input int m, input int n, input int k, input int bw);
        return ((m + k) * n) / bw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mat_stream_loader_skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2 : 2-entry FIFO, head is always slot0
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skid_buf2
    import dsp_sys_arr_pkg::*;
#(
    parameter int WIDTH = 2 * SNGL_FLT_SIZE
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [1:0]       count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign head    = slot0;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mat_stream_loader.sv
// ---------------------------------------------------------------------------
// mat_stream_loader : streams A (row-major) then B (column-major) from memory
// Optional MAT_LOADER_PERF_EN adds stall_cycles / xfer_cycles.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mat_stream_loader
    import dsp_sys_arr_pkg::*;
#(
    parameter int M  = 2,
    parameter int N  = 2,
    parameter int K  = 2,
    parameter int BW = 2,
    parameter int AW = 16
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        start,
    input  logic [AW-1:0]               base_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_rd_en,
    output logic [AW-1:0]               mem_addr,
    input  logic [BW*SNGL_FLT_SIZE-1:0] mem_rd_dat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BW*SNGL_FLT_SIZE-1:0] out_stream,
    output logic                        out_last
`ifdef MAT_LOADER_PERF_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 xfer_cycles
`endif
);

    localparam int             NBEATS   = loader_nbeats(M, N, K, BW);
    localparam int             CW       = $clog2(NBEATS + 1);
    localparam logic [CW-1:0]  NB       = CW'(NBEATS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NBEATS - 1);

    if ((((M + K) * N) % BW) != 0) begin : g_bw_check
        $error("mat_stream_loader: (M+K)*N must be divisible by BW");
    end

    logic [1:0]    state;
    logic [AW-1:0] base;
    logic [CW-1:0] issued;
    logic [CW-1:0] accepted;
    logic          inflight;
    logic          done_r;
    logic          buf_full;
    logic          buf_empty;
    logic          handshake;
    logic [1:0]    buf_count;
    logic [2:0]    credit_used;

    assign handshake = out_valid & out_ready;
    assign buf_count = {buf_full, ~buf_full & ~buf_empty};

    // A beat leaving this cycle frees its slot for a read issued this cycle,
    // which is what lets the loader sustain one beat per clock.
    assign credit_used = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, handshake};
    assign mem_rd_en   = (state == LD_STREAM) && (issued < NB) && (credit_used < 3'd2);
    assign mem_addr    = (state == LD_STREAM) ? base + AW'(issued) : '0;

    assign busy      = (state != LD_IDLE);
    assign done      = done_r;
    assign out_valid = ~buf_empty;
    assign out_last  = out_valid && (accepted == LAST_IDX);

    skid_buf2 #(
        .WIDTH (BW * SNGL_FLT_SIZE)
    ) u_buf (
        .clk   (clk),
        .nrst  (nrst),
        .push  (inflight),
        .din   (mem_rd_dat),
        .pop   (handshake),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (out_stream)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= LD_IDLE;
            base     <= '0;
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            inflight <= mem_rd_en;
            if (mem_rd_en) issued   <= issued + CW'(1);
            if (handshake) accepted <= accepted + CW'(1);
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        base     <= base_addr;
                        issued   <= '0;
                        accepted <= '0;
                        state    <= LD_STREAM;
                    end
                end
                LD_STREAM: begin
                    if (issued == NB) state <= LD_DRAIN;
                end
                default: ;
            endcase
            if ((state != LD_IDLE) && handshake && (accepted == LAST_IDX)) begin
                state  <= LD_IDLE;
                done_r <= 1'b1;
            end
        end
    end

`ifdef MAT_LOADER_PERF_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cycles <= '0;
            xfer_cycles  <= '0;
        end else if ((state == LD_IDLE) && start) begin
            stall_cycles <= '0;
            xfer_cycles  <= '0;
        end else begin
            if (busy && out_valid && !out_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (busy && (xfer_cycles != '1))
                xfer_cycles <= xfer_cycles + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mat_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_mat_stream_loader : directed bench for mat_stream_loader (two configs)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mat_stream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;

    logic        start1, busy1, done1, rd1, valid1, ready1, last1;
    logic [15:0] base1, addr1;
    logic [63:0] rdat1, strm1;

    logic         start2, busy2, done2, rd2, valid2, ready2, last2;
    logic [15:0]  base2, addr2;
    logic [127:0] rdat2, strm2;

`ifdef MAT_LOADER_PERF_EN
    logic [31:0] stall1, xfer1, stall2, xfer2;
`endif

    mat_stream_loader #(.M(2), .N(2), .K(2), .BW(2), .AW(16)) dut1 (
        .clk(clk), .nrst(nrst), .start(start1), .base_addr(base1),
        .busy(busy1), .done(done1), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_rd_dat(rdat1), .out_valid(valid1), .out_ready(ready1),
        .out_stream(strm1), .out_last(last1)
`ifdef MAT_LOADER_PERF_EN
        , .stall_cycles(stall1), .xfer_cycles(xfer1)
`endif
    );

    mat_stream_loader #(.M(3), .N(2), .K(1), .BW(4), .AW(16)) dut2 (
        .clk(clk), .nrst(nrst), .start(start2), .base_addr(base2),
        .busy(busy2), .done(done2), .mem_rd_en(rd2), .mem_addr(addr2),
        .mem_rd_dat(rdat2), .out_valid(valid2), .out_ready(ready2),
        .out_stream(strm2), .out_last(last2)
`ifdef MAT_LOADER_PERF_EN
        , .stall_cycles(stall2), .xfer_cycles(xfer2)
`endif
    );

    // 1-cycle-latency memories, indexed by the low address byte
    logic [63:0]  mem1 [0:255];
    logic [127:0] mem2 [0:255];
    always @(posedge clk) if (rd1) rdat1 <= mem1[addr1[7:0]];
    always @(posedge clk) if (rd2) rdat2 <= mem2[addr2[7:0]];

    logic [63:0]  exp1 [0:3];
    logic [127:0] exp2 [0:1];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        busy;
        logic        done;
        logic        rd;
        logic [15:0] addr;
        logic        valid;
        logic        last;
        logic [63:0] data;
    } vec_t;

    vec_t tbl [0:8];

    task automatic run_table(input string tag);
        for (int t = 0; t < 9; t++) begin
            @(posedge clk); #1;
            start1 = tbl[t].start;
            ready1 = tbl[t].ready;
            base1  = 16'h0010;
            @(negedge clk);
            chk($sformatf("%s_t%0d", tag, t),
                {busy1, done1, rd1, (tbl[t].rd ? addr1 : 16'h0), valid1, last1,
                 (tbl[t].valid ? strm1 : 64'h0)},
                {tbl[t].busy, tbl[t].done, tbl[t].rd, (tbl[t].rd ? tbl[t].addr : 16'h0),
                 tbl[t].valid, tbl[t].last, (tbl[t].valid ? tbl[t].data : 64'h0)});
        end
    endtask

    // mode 0: ready held high, extra start pulse mid-stream; mode 1: ready 1,0,0,...
    task automatic run_stream(input int mode, input string tag);
        int beats = 0, dones = 0, unstable = 0, issued = 0, max_out = 0;
        int stalls = 0, busy_cyc = 0, last_bad = 0, data_bad = 0, done_busy = 0;
        logic pv = 1'b0, pr = 1'b1;
        logic [63:0] ps = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            start1 = (cyc == 0) || (mode == 0 && cyc == 2);
            ready1 = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            base1  = 16'h0010;
            @(negedge clk);
            if (pv && !pr && (!valid1 || strm1 !== ps)) unstable++;
            if (rd1) issued++;
            if (valid1 && ready1) begin
                if (beats > 3 || strm1 !== exp1[beats]) data_bad++;
                if (last1 !== (beats == 3)) last_bad++;
                beats++;
            end else if (last1 && !valid1) begin
                last_bad++;
            end
            if (issued - beats > max_out) max_out = issued - beats;
            if (valid1 && !ready1 && busy1) stalls++;
            if (busy1) busy_cyc++;
            if (done1) begin
                dones++;
                if (busy1) done_busy++;
            end
            pv = valid1; pr = ready1; ps = strm1;
        end
        chk({tag, "_beats"}, beats, 4);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_data"}, data_bad, 0);
        chk({tag, "_last"}, last_bad, 0);
        chk({tag, "_stable"}, unstable, 0);
        chk({tag, "_outstanding_le2"}, (max_out <= 2), 1);
        chk({tag, "_busy_low_at_done"}, done_busy, 0);
`ifdef MAT_LOADER_PERF_EN
        chk({tag, "_stall_cycles"}, stall1, stalls);
        chk({tag, "_xfer_cycles"}, xfer1, busy_cyc);
`endif
    endtask

    task automatic run_held_start();
        int td = -1, beats = 0, dones = 0, data_bad = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            start1 = (td < 0);
            ready1 = 1'b1;
            base1  = 16'h0010;
            @(negedge clk);
            if (valid1 && ready1) begin
                if (strm1 !== exp1[beats % 4]) data_bad++;
                beats++;
            end
            if (done1) begin
                dones++;
                if (td < 0) begin
                    td = cyc;
                    chk("held_first_done_cycle", cyc, 7);
                    chk("held_busy_low_at_done", busy1, 1'b0);
                end
            end
            if (td >= 0 && cyc == td + 1) chk("held_restart_busy", busy1, 1'b1);
            if (td >= 0 && cyc == td + 2) chk("held_no_early_valid", valid1, 1'b0);
            if (td >= 0 && cyc == td + 3) chk("held_second_first_beat", {valid1, strm1}, {1'b1, exp1[0]});
        end
        chk("held_done_seen", (td >= 0), 1);
        chk("held_total_beats", beats, 8);
        chk("held_total_dones", dones, 2);
        chk("held_data", data_bad, 0);
    endtask

    task automatic run_dut2(input logic [15:0] base, input logic [15:0] a0,
                            input logic [15:0] a1, input string tag);
        int nrd = 0, nb = 0, nd = 0, fv = -1;
        logic [15:0]  rda [0:1];
        logic [127:0] got [0:1];
        logic [1:0]   lastv;
        rda[0] = '0; rda[1] = '0; got[0] = '0; got[1] = '0; lastv = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            start2 = (cyc == 0);
            base2  = base;
            ready2 = 1'b1;
            @(negedge clk);
            if (rd2) begin
                if (nrd < 2) rda[nrd] = addr2;
                nrd++;
            end
            if (valid2 && ready2) begin
                if (nb < 2) begin
                    got[nb]   = strm2;
                    lastv[nb] = last2;
                end
                if (nb == 0) fv = cyc;
                nb++;
            end
            if (done2) nd++;
        end
        chk({tag, "_reads"}, nrd, 2);
        chk({tag, "_addr0"}, rda[0], a0);
        chk({tag, "_addr1"}, rda[1], a1);
        chk({tag, "_beats"}, nb, 2);
        chk({tag, "_beat0"}, got[0], exp2[0]);
        chk({tag, "_beat1"}, got[1], exp2[1]);
        chk({tag, "_last_flags"}, lastv, 2'b10);
        chk({tag, "_dones"}, nd, 1);
        chk({tag, "_first_valid_cycle"}, fv, 3);
    endtask

    initial begin
        nrst = 1'b0;
        start1 = 1'b0; ready1 = 1'b1; base1 = 16'h0010;
        start2 = 1'b0; ready2 = 1'b1; base2 = 16'h0020;

        exp1[0] = {32'h4000_0000, 32'h3F80_0000};
        exp1[1] = {32'h4080_0000, 32'h4040_0000};
        exp1[2] = {32'h40C0_0000, 32'h40A0_0000};
        exp1[3] = {32'h4100_0000, 32'h40E0_0000};
        exp2[0] = {32'h0000_0A11, 32'h0000_0A10, 32'h0000_0A01, 32'h0000_0A00};
        exp2[1] = {32'h0000_0B10, 32'h0000_0B00, 32'h0000_0A21, 32'h0000_0A20};
        for (int i = 0; i < 256; i++) begin
            mem1[i] = {32'hBAD0_0000, 24'h0, i[7:0]};
            mem2[i] = {96'hBAD, 24'h0, i[7:0]};
        end
        for (int j = 0; j < 4; j++) mem1[8'h10 + j] = exp1[j];
        mem2[8'h20] = exp2[0];
        mem2[8'h21] = exp2[1];
        mem2[8'hFF] = exp2[0];
        mem2[8'h00] = exp2[1];

        //               start ready busy done rd  addr      valid last data
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 64'h0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0012, 1'b1, 1'b0, exp1[0]};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 1'b0, exp1[1]};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, exp1[2]};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, exp1[3]};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 64'h0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 64'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dut1_outputs", {busy1, done1, rd1, addr1, valid1, last1, strm1}, '0);
        chk("reset_dut2_outputs", {busy2, done2, rd2, addr2, valid2, last2}, '0);
        nrst = 1'b1;

        run_table("nominal");
        run_stream(1, "backpressure");
        run_stream(0, "restart_ignored");

        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            start1 = (t == 0);
            ready1 = 1'b1;
        end
        @(posedge clk); #1;
        chk("midrst_two_accepted_inflight", {valid1, rd1}, 2'b10);
        nrst = 1'b0;
        #1;
        chk("midrst_outputs_zero", {busy1, done1, rd1, addr1, valid1, last1, strm1}, '0);
        @(negedge clk);
        nrst = 1'b1;
        run_table("after_reset");

        run_held_start();

        run_dut2(16'h0020, 16'h0020, 16'h0021, "cfg2");
        run_dut2(16'hFFFF, 16'hFFFF, 16'h0000, "cfg2_wrap");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
